io_clk_divider_bank: RTL and testbench
======================================

Name: io_clk_divider_bank

Overview:
Parametrised bank of CHANNELS programmable clock-enable and divided-clock generators, all running entirely in the sys_clk domain. It replaces per-channel multi-source clock muxing with sys_clk-derived outputs. Each channel produces either a 50% duty square wave or a single-cycle strobe, and also a rising-edge strobe for IO shifters. Configuration uses the standard 16-bit IO config register interface with byte-lane write enables and combinational readback. A global resync input phase-aligns all channels.

Parameters:
CHANNELS, 4, number of divider channels; range 1..16.
ADDR_WIDTH, 2, config address width; must satisfy 2^ADDR_WIDTH >= CHANNELS.
DIV_WIDTH, 14, divider field width; range 1..14.

Ports:
sys_clk  input  1  system clock; the only clock.
sync_rst  input  1  synchronous reset, active-high.
clk_en  input  1  global clock enable; when low, all state holds, including config writes.
resync  input  1  one-cycle pulse; restarts every channel counter on the same edge.
ConfigurationAddr  input  ADDR_WIDTH  selects the channel register.
ConfigWriteEnUpper  input  1  writes ConfigInput[15:8] to the addressed register.
ConfigWriteEnLower  input  1  writes ConfigInput[7:0] to the addressed register.
ConfigInput  input  16  write data.
ConfigOutput  output  16  combinational readback of the addressed register; 0 if the address is >= CHANNELS.
div_out  output  CHANNELS  per-channel divided clock (mode 0) or strobe (mode 1); registered.
div_rise  output  CHANNELS  one-cycle pulse on the cycle where div_out goes 0->1; registered.

Behaviour:
- Register layout, per channel:
  - [DIV_WIDTH-1:0] DIV.
  - [13:DIV_WIDTH] reserved; reads 0 and writes are ignored.
  - [14] MODE: 0 = toggle, 1 = strobe.
  - [15] EN.
- Reset: all registers 0, all counters 0, div_out 0, div_rise 0. Reset overrides clk_en.
- Write: takes effect at the edge where clk_en=1 and a write enable is high. Byte lanes are independent; both lanes may be written on the same edge.
- Writes to an address >= CHANNELS are ignored.
- Any write to a channel restarts that channel on the same edge: cnt<=new DIV, div_out<=0, div_rise<=0.
- resync=1 restarts every channel with its current DIV. If a write and resync coincide, the written channel uses the new value.
- Counter step, per enabled channel, on each edge with clk_en=1, no restart and EN=1:
  - If cnt!=0, cnt<=cnt-1.
  - If cnt==0, cnt<=DIV and an event fires.
- Event action:
  - MODE 0: div_out toggles.
  - MODE 1: div_out<=1 for exactly one cycle, then 0 on the next edge unless another event fires.
- div_rise <= event AND div_out will become 1. In MODE 1, div_rise equals div_out.
- Resulting periods:
  - MODE 0: 2*(DIV+1) sys_clk cycles at 50% duty. DIV=0 gives sys_clk/2.
  - MODE 1: one pulse every DIV+1 cycles. DIV=0 keeps div_out high continuously.
- First event: DIV+1 enabled edges after the restart edge.
- EN=0: cnt held at DIV, div_out and div_rise forced 0 on the next enabled edge. Setting EN=1 is a write, so it restarts the channel.
- clk_en=0: nothing changes and outputs hold their values. Counting resumes from the held state with no lost or extra events.
- Reset mid-operation: all outputs return to 0 on the following edge and all channels are disabled.

Decomposition:
- Package io_clk_pkg: field constants CFG_EN_BIT=15, CFG_MODE_BIT=14, CFG_DIV_MSB=13; MODE_TOGGLE/MODE_STROBE enum.
- Sub-module io_clk_div_channel holds one channel's register, counter and output flops. Its inputs are write lanes, restart and clk_en.
- The top level holds the address decode, the readback mux and a generate loop over CHANNELS.

Test Plan:
1. Reset, then read all addresses -> ConfigOutput=0x0000; div_out=0 and div_rise=0 for 20 cycles.
2. Write ch0=0x8003 (EN, toggle, DIV=3) -> div_out[0] goes high 4 edges after the write, period 8 cycles at 50% duty. div_rise[0] pulses once per period.
3. Write ch1=0xC002 (EN, strobe, DIV=2) -> div_out[1] is a one-cycle pulse every 3 cycles. Write ch1=0xC000 -> div_out[1] is constant 1 from the first event.
4. With ch0 and ch1 running, hold clk_en low for 5 cycles mid-period -> outputs frozen; the remaining count resumes exactly. A resync pulse then realigns both channels so their first events are DIV+1 edges later.
5. Write only the lower byte 0x05 to a running ch2=0x8001 -> register reads 0x8005, the channel restarts and div_out[2]=0 on the next cycle. A write to address 3 with CHANNELS=3 is ignored and reads 0.
6. Assert sync_rst while channels toggle -> all outputs 0 after the edge, registers 0, and no activity until reprogrammed.

Source files
------------

// File: rtl/io_clk_pkg.sv
// Shared field positions and mode encoding for the IO clock divider bank.
package io_clk_pkg;

  localparam int CFG_W        = 16;
  localparam int CFG_EN_BIT   = 15;
  localparam int CFG_MODE_BIT = 14;
  localparam int CFG_DIV_MSB  = 13;

  typedef enum logic {
    MODE_TOGGLE = 1'b0,
    MODE_STROBE = 1'b1
  } mode_e;

  // Bits of a channel register that hold state; reserved bits above DIV stay 0.
  function automatic logic [CFG_W-1:0] cfg_write_mask(input int div_w);
    logic [CFG_W-1:0] m;
    m = '0;
    m[CFG_EN_BIT]   = 1'b1;
    m[CFG_MODE_BIT] = 1'b1;
    for (int i = 0; i <= CFG_DIV_MSB; i++) begin
      if (i < div_w) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/io_clk_divider_bank_if.sv
// Configuration register bus of the divider bank: address, byte-lane writes, readback.
interface io_clk_divider_bank_if #(
  parameter int ADDR_WIDTH = 2
);
  logic [ADDR_WIDTH-1:0] ConfigurationAddr;
  logic                  ConfigWriteEnUpper;
  logic                  ConfigWriteEnLower;
  logic [15:0]           ConfigInput;
  logic [15:0]           ConfigOutput;

  modport master (
    output ConfigurationAddr,
    output ConfigWriteEnUpper,
    output ConfigWriteEnLower,
    output ConfigInput,
    input  ConfigOutput
  );

  modport slave (
    input  ConfigurationAddr,
    input  ConfigWriteEnUpper,
    input  ConfigWriteEnLower,
    input  ConfigInput,
    output ConfigOutput
  );
endinterface

// File: rtl/io_clk_div_channel.sv
// One divider channel: config register, down-counter and registered outputs.
module io_clk_div_channel
  import io_clk_pkg::*;
#(
  parameter int DIV_WIDTH = 14
) (
  input  logic             sys_clk,
  input  logic             sync_rst,
  input  logic             clk_en,
  input  logic             resync,
  input  logic             we_upper,
  input  logic             we_lower,
  input  logic [CFG_W-1:0] wdata,
  output logic [CFG_W-1:0] cfg_rd,
  output logic             div_out,
  output logic             div_rise
);

  localparam logic [CFG_W-1:0] WMASK = cfg_write_mask(DIV_WIDTH);

  logic [CFG_W-1:0]     cfg_q, cfg_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic                 out_q, out_d;
  logic                 rise_q, rise_d;
  logic                 restart;
  logic                 en;
  mode_e                mode;

  // Next register value, counter step and event action for this channel.
  always_comb begin
    cfg_d = cfg_q;
    if (we_upper) cfg_d[15:8] = wdata[15:8];
    if (we_lower) cfg_d[7:0]  = wdata[7:0];
    cfg_d = cfg_d & WMASK;

    restart = we_upper | we_lower | resync;
    en      = cfg_q[CFG_EN_BIT];
    mode    = mode_e'(cfg_q[CFG_MODE_BIT]);

    cnt_d  = cnt_q;
    out_d  = out_q;
    rise_d = 1'b0;

    if (restart) begin
      // A write restarts with the freshly written DIV; resync alone sees the same value.
      cnt_d = cfg_d[DIV_WIDTH-1:0];
      out_d = 1'b0;
    end else if (!en) begin
      cnt_d = cfg_q[DIV_WIDTH-1:0];
      out_d = 1'b0;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
      if (mode == MODE_STROBE) out_d = 1'b0;
    end else begin
      cnt_d = cfg_q[DIV_WIDTH-1:0];
      if (mode == MODE_STROBE) begin
        out_d  = 1'b1;
        rise_d = 1'b1;
      end else begin
        out_d  = ~out_q;
        rise_d = ~out_q;
      end
    end
  end

  // State update; clk_en low freezes everything including config writes.
  always_ff @(posedge sys_clk) begin
    if (sync_rst) begin
      cfg_q  <= '0;
      cnt_q  <= '0;
      out_q  <= 1'b0;
      rise_q <= 1'b0;
    end else if (clk_en) begin
      cfg_q  <= cfg_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      rise_q <= rise_d;
    end
  end

  assign cfg_rd   = cfg_q;
  assign div_out  = out_q;
  assign div_rise = rise_q;

endmodule

// File: rtl/io_clk_divider_bank.sv
// Bank of sys_clk-derived divided clocks/strobes with a shared config register bus.
module io_clk_divider_bank
  import io_clk_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int ADDR_WIDTH = 2,
  parameter int DIV_WIDTH  = 14
) (
  input  logic                sys_clk,
  input  logic                sync_rst,
  input  logic                clk_en,
  input  logic                resync,
  io_clk_divider_bank_if.slave cfg,
  output logic [CHANNELS-1:0] div_out,
  output logic [CHANNELS-1:0] div_rise
);

  logic [CFG_W-1:0]    cfg_rd [CHANNELS];
  logic [CHANNELS-1:0] sel;

  // One-hot channel select; addresses beyond the last channel select nothing.
  always_comb begin
    sel = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      sel[i] = (int'(cfg.ConfigurationAddr) == i);
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    io_clk_div_channel #(
      .DIV_WIDTH (DIV_WIDTH)
    ) u_ch (
      .sys_clk  (sys_clk),
      .sync_rst (sync_rst),
      .clk_en   (clk_en),
      .resync   (resync),
      .we_upper (cfg.ConfigWriteEnUpper & sel[g]),
      .we_lower (cfg.ConfigWriteEnLower & sel[g]),
      .wdata    (cfg.ConfigInput),
      .cfg_rd   (cfg_rd[g]),
      .div_out  (div_out[g]),
      .div_rise (div_rise[g])
    );
  end

  // Combinational readback of the addressed channel register.
  always_comb begin
    cfg.ConfigOutput = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (sel[i]) cfg.ConfigOutput = cfg_rd[i];
    end
  end

endmodule

// File: tb/tb_io_clk_divider_bank.sv
// Scoreboard bench for io_clk_divider_bank with three channels and a 12-bit DIV field.
module tb_io_clk_divider_bank;

  localparam int CH = 3;
  localparam int AW = 2;
  localparam int DW = 12;
  localparam logic [15:0] MASK = 16'hCFFF;

  logic          sys_clk;
  logic          sync_rst;
  logic          clk_en;
  logic          resync;
  logic [CH-1:0] div_out;
  logic [CH-1:0] div_rise;

  io_clk_divider_bank_if #(.ADDR_WIDTH(AW)) cfg_if ();

  io_clk_divider_bank #(
    .CHANNELS   (CH),
    .ADDR_WIDTH (AW),
    .DIV_WIDTH  (DW)
  ) dut (
    .sys_clk  (sys_clk),
    .sync_rst (sync_rst),
    .clk_en   (clk_en),
    .resync   (resync),
    .cfg      (cfg_if),
    .div_out  (div_out),
    .div_rise (div_rise)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [15:0]     m_reg [CH];
  int              m_ph  [CH];
  logic [CH-1:0]   m_out;
  logic [CH-1:0]   m_rise;
  logic [2*CH-1:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference: each channel counts a phase upward from 0 and fires when it reaches DIV.
  task automatic model_step(input bit r, input bit ce, input bit rs, input bit wu,
                            input bit wl, input logic [1:0] a, input logic [15:0] d);
    bit wr;
    int div;
    if (r) begin
      for (int c = 0; c < CH; c++) begin
        m_reg[c] = '0;
        m_ph[c]  = 0;
      end
      m_out  = '0;
      m_rise = '0;
    end else if (ce) begin
      for (int c = 0; c < CH; c++) begin
        wr = (wu || wl) && (int'(a) == c);
        if (wr) begin
          if (wu) m_reg[c][15:8] = d[15:8];
          if (wl) m_reg[c][7:0]  = d[7:0];
          m_reg[c] = m_reg[c] & MASK;
        end
        div = int'(m_reg[c][11:0]);
        if (wr || rs || !m_reg[c][15]) begin
          m_ph[c]   = 0;
          m_out[c]  = 1'b0;
          m_rise[c] = 1'b0;
        end else if (m_ph[c] == div) begin
          m_ph[c] = 0;
          if (m_reg[c][14]) begin
            m_out[c]  = 1'b1;
            m_rise[c] = 1'b1;
          end else begin
            m_out[c]  = ~m_out[c];
            m_rise[c] = m_out[c];
          end
        end else begin
          m_ph[c]   = m_ph[c] + 1;
          m_rise[c] = 1'b0;
          if (m_reg[c][14]) m_out[c] = 1'b0;
        end
      end
    end
  endtask

  task automatic cycle(input bit r, input bit ce, input bit rs, input bit wu,
                       input bit wl, input logic [1:0] a, input logic [15:0] d);
    logic [2*CH-1:0] got;
    logic [15:0]     exp_rd;
    @(negedge sys_clk);
    sync_rst                  = r;
    clk_en                    = ce;
    resync                    = rs;
    cfg_if.ConfigWriteEnUpper = wu;
    cfg_if.ConfigWriteEnLower = wl;
    cfg_if.ConfigurationAddr  = a;
    cfg_if.ConfigInput        = d;
    #1;
    if (!r) begin
      exp_rd = (int'(a) < CH) ? m_reg[a] : 16'h0000;
      check($sformatf("readback[%0d]", a), 32'(cfg_if.ConfigOutput), 32'(exp_rd));
    end
    @(posedge sys_clk);
    model_step(r, ce, rs, wu, wl, a, d);
    exp_q.push_back({m_rise, m_out});
    #1;
    got = {div_rise, div_out};
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'(exp_q.size()), 32'd1);
    end else begin
      check("outputs{rise,out}", 32'(got), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 1, 0, 0, 0, 2'(i), 16'h0000);
  endtask

  task automatic write(input logic [1:0] a, input logic [15:0] d);
    cycle(0, 1, 0, 1, 1, a, d);
  endtask

  initial begin
    sync_rst                  = 1'b1;
    clk_en                    = 1'b0;
    resync                    = 1'b0;
    cfg_if.ConfigWriteEnUpper = 1'b0;
    cfg_if.ConfigWriteEnLower = 1'b0;
    cfg_if.ConfigurationAddr  = '0;
    cfg_if.ConfigInput        = '0;
    for (int c = 0; c < CH; c++) begin
      m_reg[c] = '0;
      m_ph[c]  = 0;
    end
    m_out  = '0;
    m_rise = '0;

    // Reset (with clk_en low, reset still wins), then quiet readback of every address.
    cycle(1, 0, 0, 0, 0, 2'd0, 16'h0000);
    cycle(1, 1, 0, 0, 0, 2'd0, 16'h0000);
    idle(20);

    // Toggle channel, DIV=3.
    write(2'd0, 16'h8003);
    idle(20);

    // Strobe channel DIV=2, then DIV=0.
    write(2'd1, 16'hC002);
    idle(10);
    write(2'd1, 16'hC000);
    idle(6);

    // Freeze mid-period, with an attempted write that must be ignored.
    idle(3);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 2'd0, 16'h0000);
    cycle(0, 0, 0, 1, 1, 2'd0, 16'h8001);
    idle(7);
    write(2'd1, 16'hC002);
    idle(2);
    cycle(0, 1, 1, 0, 0, 2'd0, 16'h0000);
    idle(10);

    // Lower-byte only write to a running channel.
    write(2'd2, 16'h8001);
    idle(6);
    cycle(0, 1, 0, 0, 1, 2'd2, 16'hAA05);
    idle(8);
    // Upper-byte only write disables ch0.
    cycle(0, 1, 0, 1, 0, 2'd0, 16'h0033);
    idle(4);

    // Unmapped address and reserved bits.
    write(2'd3, 16'hFFFF);
    cycle(0, 1, 0, 0, 0, 2'd3, 16'h0000);
    write(2'd1, 16'hFFFF);
    cycle(0, 1, 0, 0, 0, 2'd1, 16'h0000);
    write(2'd1, 16'hC001);
    write(2'd0, 16'h8002);
    idle(5);

    // Resync coinciding with a write: written channel uses its new DIV.
    cycle(0, 1, 1, 1, 1, 2'd0, 16'h8001);
    idle(10);

    // Randomised traffic.
    for (int i = 0; i < 80; i++) begin
      bit          ce, rs, w, wu, wl;
      logic [1:0]  a;
      logic [15:0] d;
      ce = ($urandom_range(0, 7) != 0);
      rs = ($urandom_range(0, 15) == 0);
      w  = ($urandom_range(0, 5) == 0);
      wu = w && ($urandom_range(0, 3) != 0);
      wl = w && (!wu || $urandom_range(0, 1) == 1);
      a  = 2'($urandom_range(0, 3));
      d  = {1'b1, 1'($urandom_range(0, 1)), 2'b00, 12'($urandom_range(0, 4))};
      cycle(0, ce, rs, wu, wl, a, d);
    end

    // Reset while running, then confirm silence.
    write(2'd0, 16'h8000);
    idle(3);
    cycle(1, 1, 0, 0, 0, 2'd0, 16'h0000);
    idle(12);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
